// File: rtl/mbist_seq_if.sv
// Control and serial-test bundle between the configuration register block,
// the MBIST sequencer and the MBIST wrapper's serial port.
interface mbist_seq_if #(
  parameter int BIST_NO_SRAM = 4,
  parameter int BIST_ADDR_WD = 9,
  parameter int CHAIN_LEN    = BIST_NO_SRAM * BIST_ADDR_WD,
  parameter int TMO_WD       = 20
);
  // start_i is a one-cycle request taken only when the sequencer is idle (busy_o=0);
  // done_o is the matching one-cycle completion pulse. Results are valid from done_o.
  logic                    start_i;
  logic                    abort_i;
  logic [CHAIN_LEN-1:0]    load_vec_i;
  logic [TMO_WD-1:0]       tmo_limit_i;
  logic                    bist_en_o;
  logic                    bist_run_o;
  logic                    bist_shift_o;
  logic                    bist_load_o;
  logic                    bist_sdi_o;
  logic                    bist_done_i;
  logic                    bist_sdo_i;
  logic [BIST_NO_SRAM-1:0] bist_error_i;
  logic                    busy_o;
  logic                    done_o;
  logic                    pass_o;
  logic                    timeout_o;
  logic [CHAIN_LEN-1:0]    result_vec_o;
  logic [2:0]              dbg_state;

  modport master (
    input  start_i, abort_i, load_vec_i, tmo_limit_i,
           bist_done_i, bist_sdo_i, bist_error_i,
    output bist_en_o, bist_run_o, bist_shift_o, bist_load_o, bist_sdi_o,
           busy_o, done_o, pass_o, timeout_o, result_vec_o, dbg_state
  );

  modport slave (
    output start_i, abort_i, load_vec_i, tmo_limit_i,
           bist_done_i, bist_sdo_i, bist_error_i,
    input  bist_en_o, bist_run_o, bist_shift_o, bist_load_o, bist_sdi_o,
           busy_o, done_o, pass_o, timeout_o, result_vec_o, dbg_state
  );
endinterface

// File: rtl/mbist_seq.sv
// MBIST sequencer: preload repair chain, load, run, unload error chain.
// Optional RUN timeout is enabled by defining MBIST_SEQ_TIMEOUT_EN.
module mbist_seq #(
  parameter int BIST_NO_SRAM = 4,
  parameter int BIST_ADDR_WD = 9,
  parameter int CHAIN_LEN    = BIST_NO_SRAM * BIST_ADDR_WD,
  parameter int TMO_WD       = 20
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  mbist_seq_if.master  bus
);
  localparam int                CNT_WD   = $clog2(CHAIN_LEN);
  localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRELOAD = 3'd1,
    S_LOAD    = 3'd2,
    S_RUN     = 3'd3,
    S_UNLOAD  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t               state, next_state;
  logic [CNT_WD-1:0]    cnt, cnt_d;
  logic [CHAIN_LEN-1:0] shadow, shadow_d;
  logic [CHAIN_LEN-1:0] result_q, result_d;
  logic                 run_seen;
  logic                 done_ok, tmo_hit, launch;
  logic en_q, run_q, shift_q, load_q, sdi_q, busy_q, done_q, pass_q, tmo_q;
  logic en_d, run_d, shift_d, load_d, sdi_d, busy_d, done_d, pass_d, tmo_d;

  // bist_done_i is only trusted from the second RUN cycle on.
  assign done_ok = (state == S_RUN) && run_seen && bus.bist_done_i;
  assign launch  = (state == S_IDLE) && (next_state == S_PRELOAD);

`ifdef MBIST_SEQ_TIMEOUT_EN
  logic [TMO_WD-1:0] tmo_cnt, tmo_lim;
  assign tmo_lim = (bus.tmo_limit_i == '0) ? TMO_WD'(1) : bus.tmo_limit_i;
  assign tmo_hit = (state == S_RUN) && !done_ok && (tmo_cnt == tmo_lim - TMO_WD'(1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state != S_RUN) tmo_cnt <= '0;
    else                            tmo_cnt <= tmo_cnt + TMO_WD'(1);
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^bus.tmo_limit_i;
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:    if (bus.start_i)       next_state = S_PRELOAD;
      S_PRELOAD: if (cnt == CNT_LAST)   next_state = S_LOAD;
      S_LOAD:                           next_state = S_RUN;
      S_RUN:     if (done_ok || tmo_hit) next_state = S_UNLOAD;
      S_UNLOAD:  if (cnt == CNT_LAST)   next_state = S_DONE;
      S_DONE:                           next_state = S_IDLE;
      default:                          next_state = S_IDLE;
    endcase
    if (bus.abort_i) next_state = S_IDLE;
  end

  // Outputs are computed from next_state so they are registered yet line up with the state.
  always_comb begin
    cnt_d    = cnt;
    shadow_d = shadow;
    result_d = result_q;
    pass_d   = pass_q;
    tmo_d    = tmo_q;
    if (next_state != state)                          cnt_d = '0;
    else if (state == S_PRELOAD || state == S_UNLOAD) cnt_d = cnt + CNT_WD'(1);
    if (launch) begin
      shadow_d = bus.load_vec_i;
      result_d = '0;
      pass_d   = 1'b0;
      tmo_d    = 1'b0;
    end
    if (done_ok) pass_d = ~|bus.bist_error_i;
    if (tmo_hit) begin
      tmo_d  = 1'b1;
      pass_d = 1'b0;
    end
    if (state == S_UNLOAD) result_d[cnt] = bus.bist_sdo_i;
    if (bus.abort_i) pass_d = 1'b0;
    en_d    = (next_state == S_PRELOAD) || (next_state == S_LOAD) ||
              (next_state == S_RUN)     || (next_state == S_UNLOAD);
    shift_d = (next_state == S_PRELOAD) || (next_state == S_UNLOAD);
    load_d  = (next_state == S_LOAD);
    run_d   = (next_state == S_RUN);
    sdi_d   = (next_state == S_PRELOAD) ? shadow_d[cnt_d] : 1'b0;
    busy_d  = (next_state != S_IDLE);
    done_d  = (next_state == S_DONE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt      <= '0;
      shadow   <= '0;
      result_q <= '0;
      run_seen <= 1'b0;
      en_q     <= 1'b0;
      run_q    <= 1'b0;
      shift_q  <= 1'b0;
      load_q   <= 1'b0;
      sdi_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      shadow   <= shadow_d;
      result_q <= result_d;
      run_seen <= (state == S_RUN);
      en_q     <= en_d;
      run_q    <= run_d;
      shift_q  <= shift_d;
      load_q   <= load_d;
      sdi_q    <= sdi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.bist_en_o    = en_q;
  assign bus.bist_run_o   = run_q;
  assign bus.bist_shift_o = shift_q;
  assign bus.bist_load_o  = load_q;
  assign bus.bist_sdi_o   = sdi_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.pass_o       = pass_q;
  assign bus.timeout_o    = tmo_q;
  assign bus.result_vec_o = result_q;
  assign bus.dbg_state    = state;
endmodule

// File: tb/tb_mbist_seq.sv
// Directed bench for mbist_seq: preload order, clean/error runs, early done,
// restart while busy, abort, reset and (when enabled) the RUN timeout.
module tb_mbist_seq;
  localparam int CL = 36;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mbist_seq_if bus_if ();

  mbist_seq dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus_if)
  );

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int done_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus_if.done_o === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [CL-1:0] got, vec, stream;
    int cs, dc, shift_n, lat;

    bus_if.start_i      = 1'b0;
    bus_if.abort_i      = 1'b0;
    bus_if.load_vec_i   = '0;
    bus_if.tmo_limit_i  = 20'd1000;
    bus_if.bist_done_i  = 1'b0;
    bus_if.bist_sdo_i   = 1'b0;
    bus_if.bist_error_i = '0;

    // reset state
    repeat (3) step();
    check("reset_ctrl", {bus_if.busy_o, bus_if.bist_en_o, bus_if.bist_run_o, bus_if.bist_shift_o,
                         bus_if.bist_load_o, bus_if.bist_sdi_o, bus_if.done_o, bus_if.pass_o,
                         bus_if.timeout_o}, 9'b0);
    check("reset_result", bus_if.result_vec_o, 36'h0);
    check("reset_state", bus_if.dbg_state, 3'd0);
    rst = 1'b0;
    step();

    // clean run: preload ordering, pass, unload, latency
    vec    = 36'h0_0000_01FB;
    stream = 36'hA_5A5A_5A5A;
    bus_if.load_vec_i = vec;
    bus_if.start_i    = 1'b1;
    cs = cyc;
    dc = done_cnt;
    step();
    bus_if.start_i = 1'b0;
    got     = '0;
    shift_n = 0;
    for (int i = 0; i < CL; i++) begin
      got[i] = bus_if.bist_sdi_o;
      if (bus_if.bist_shift_o && bus_if.bist_en_o && !bus_if.bist_load_o) shift_n++;
      step();
    end
    check("preload_bits", got, 36'h0_0000_01FB);
    check("preload_len", shift_n, 36);
    check("load_pulse", {bus_if.bist_load_o, bus_if.bist_shift_o, bus_if.bist_run_o, bus_if.bist_en_o}, 4'b1001);
    step();
    check("run_entry", {bus_if.bist_run_o, bus_if.bist_load_o, bus_if.bist_shift_o, bus_if.bist_en_o}, 4'b1001);
    // done rises 50 cycles after the first RUN cycle able to accept it
    repeat (51) step();
    check("run_waits", {bus_if.bist_run_o, bus_if.bist_shift_o}, 2'b10);
    bus_if.bist_done_i = 1'b1;
    bus_if.bist_sdo_i  = stream[0];
    step();
    bus_if.bist_done_i = 1'b0;
    check("unload_entry", {bus_if.bist_shift_o, bus_if.bist_run_o, bus_if.bist_en_o, bus_if.bist_sdi_o}, 4'b1010);
    check("pass_latched", bus_if.pass_o, 1'b1);
    for (int i = 0; i < CL; i++) begin
      bus_if.bist_sdo_i = stream[i];
      step();
    end
    check("done_pulse", {bus_if.done_o, bus_if.bist_en_o, bus_if.busy_o}, 3'b101);
    lat = cyc - cs + 1;
    check("latency", lat, 127);
    check("result_clean", bus_if.result_vec_o, 36'hA_5A5A_5A5A);
    check("timeout_clean", bus_if.timeout_o, 1'b0);
    step();
    check("idle_after_done", {bus_if.done_o, bus_if.busy_o, bus_if.bist_en_o}, 3'b000);
    check("done_once", done_cnt - dc, 1);
    check("pass_hold", bus_if.pass_o, 1'b1);

    // error run: start clears results, SRAM 2 error fails the pass
    vec    = 36'hF_0F0F_0F0F;
    stream = 36'h3_C3C3_C3C3;
    bus_if.load_vec_i = vec;
    bus_if.start_i    = 1'b1;
    step();
    bus_if.start_i = 1'b0;
    check("start_clears", {bus_if.pass_o, bus_if.timeout_o}, 2'b00);
    check("result_cleared", bus_if.result_vec_o, 36'h0);
    check("preload_first", {bus_if.busy_o, bus_if.bist_en_o, bus_if.bist_shift_o, bus_if.bist_sdi_o}, 4'b1111);
    repeat (CL) step();
    step();
    step();
    bus_if.bist_done_i  = 1'b1;
    bus_if.bist_error_i = 4'b0100;
    bus_if.bist_sdo_i   = stream[0];
    step();
    bus_if.bist_done_i  = 1'b0;
    bus_if.bist_error_i = '0;
    check("pass_error", {bus_if.pass_o, bus_if.bist_shift_o}, 2'b01);
    for (int i = 0; i < CL; i++) begin
      bus_if.bist_sdo_i = stream[i];
      step();
    end
    check("done_error", {bus_if.done_o, bus_if.pass_o}, 2'b10);
    check("result_error", bus_if.result_vec_o, 36'h3_C3C3_C3C3);
    step();

    // restart while busy is ignored; done held high at RUN entry
    vec = 36'h9_8765_4321;
    bus_if.load_vec_i = vec;
    bus_if.start_i    = 1'b1;
    step();
    bus_if.start_i = 1'b0;
    got = '0;
    for (int i = 0; i < CL; i++) begin
      got[i] = bus_if.bist_sdi_o;
      if (i >= 4 && i < 7) begin
        bus_if.start_i    = 1'b1;
        bus_if.load_vec_i = '0;
      end else begin
        bus_if.start_i = 1'b0;
      end
      step();
    end
    bus_if.start_i = 1'b0;
    check("restart_ignored", got, 36'h9_8765_4321);
    check("load_after_restart", bus_if.bist_load_o, 1'b1);
    bus_if.bist_done_i = 1'b1;
    step();
    check("run1", bus_if.bist_run_o, 1'b1);
    step();
    check("early_done_ignored", {bus_if.bist_run_o, bus_if.bist_shift_o}, 2'b10);
    stream = 36'h0_0000_0001;
    bus_if.bist_sdo_i = stream[0];
    step();
    bus_if.bist_done_i = 1'b0;
    check("early_done_accepted", {bus_if.bist_run_o, bus_if.bist_shift_o, bus_if.pass_o}, 3'b011);
    for (int i = 0; i < CL; i++) begin
      bus_if.bist_sdo_i = stream[i];
      step();
    end
    check("done_early", bus_if.done_o, 1'b1);
    check("result_early", bus_if.result_vec_o, 36'h0_0000_0001);
    step();

    // abort in the 10th UNLOAD cycle
    bus_if.load_vec_i = '0;
    bus_if.start_i    = 1'b1;
    step();
    bus_if.start_i = 1'b0;
    repeat (CL) step();
    step();
    step();
    bus_if.bist_done_i = 1'b1;
    bus_if.bist_sdo_i  = 1'b1;
    step();
    bus_if.bist_done_i = 1'b0;
    dc = done_cnt;
    for (int i = 0; i < 9; i++) begin
      bus_if.bist_sdo_i = 1'b1;
      step();
    end
    bus_if.bist_sdo_i = 1'b0;
    bus_if.abort_i    = 1'b1;
    step();
    bus_if.abort_i = 1'b0;
    check("abort_state", bus_if.dbg_state, 3'd0);
    check("abort_outputs", {bus_if.busy_o, bus_if.bist_en_o, bus_if.bist_shift_o, bus_if.bist_run_o,
                            bus_if.done_o, bus_if.pass_o}, 6'b0);
    check("abort_partial", bus_if.result_vec_o, 36'h0_0000_01FF);
    step();
    check("abort_no_done", done_cnt - dc, 0);

    // start and abort together in IDLE
    bus_if.start_i = 1'b1;
    bus_if.abort_i = 1'b1;
    step();
    bus_if.start_i = 1'b0;
    bus_if.abort_i = 1'b0;
    check("start_abort_idle", {bus_if.busy_o, bus_if.bist_en_o, bus_if.dbg_state}, 5'b0);

    // reset mid-PRELOAD
    bus_if.load_vec_i = '1;
    bus_if.start_i    = 1'b1;
    step();
    bus_if.start_i = 1'b0;
    repeat (10) step();
    check("preload_mid", {bus_if.busy_o, bus_if.bist_en_o, bus_if.bist_shift_o, bus_if.bist_sdi_o}, 4'b1111);
    rst = 1'b1;
    step();
    check("reset_mid", {bus_if.busy_o, bus_if.bist_en_o, bus_if.bist_run_o, bus_if.bist_shift_o,
                        bus_if.bist_load_o, bus_if.bist_sdi_o, bus_if.done_o, bus_if.pass_o,
                        bus_if.timeout_o, bus_if.dbg_state}, 12'b0);
    rst = 1'b0;
    step();

`ifdef MBIST_SEQ_TIMEOUT_EN
    // RUN timeout after 100 cycles without done
    stream = 36'h5_5555_5555;
    bus_if.tmo_limit_i = 20'd100;
    bus_if.load_vec_i  = '0;
    bus_if.start_i     = 1'b1;
    step();
    bus_if.start_i = 1'b0;
    repeat (CL) step();
    step();
    repeat (99) step();
    check("tmo_run100", {bus_if.bist_run_o, bus_if.timeout_o}, 2'b10);
    bus_if.bist_sdo_i = stream[0];
    step();
    check("tmo_hit", {bus_if.timeout_o, bus_if.bist_shift_o, bus_if.pass_o}, 3'b110);
    for (int i = 0; i < CL; i++) begin
      bus_if.bist_sdo_i = stream[i];
      step();
    end
    check("tmo_done", {bus_if.done_o, bus_if.timeout_o}, 2'b11);
    check("tmo_result", bus_if.result_vec_o, 36'h5_5555_5555);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
